// File: rtl/seg_disp_ctrl_if.sv
// Write-request bus between the digit requesters and seg_disp_ctrl.
// Two requesters, each with its own digit index/value pair and one GNT bit.
interface seg_disp_ctrl_if #(
  parameter int IDX_W      = 3,
  parameter int DIGIT_SIZE = 4
);
  // Handshake: requester k raises REQ[k] with WR_IDXk/WR_DATAk stable and holds
  // them until GNT[k] pulses for one cycle; the write took effect at the edge
  // that raised GNT[k]. REQ[k] may then drop or present the next write.
  logic [1:0]            REQ;
  logic [IDX_W-1:0]      WR_IDX0;
  logic [DIGIT_SIZE-1:0] WR_DATA0;
  logic [IDX_W-1:0]      WR_IDX1;
  logic [DIGIT_SIZE-1:0] WR_DATA1;
  logic [1:0]            GNT;

  modport master (
    output REQ, WR_IDX0, WR_DATA0, WR_IDX1, WR_DATA1,
    input  GNT
  );

  modport slave (
    input  REQ, WR_IDX0, WR_DATA0, WR_IDX1, WR_DATA1,
    output GNT
  );
endinterface

// File: rtl/seg_disp_ctrl.sv
// Front-end for the 8-digit seven_seg driver: round-robin digit writes, refresh CE,
// blink scheduling. Optional leading-zero blanking under SEG_DISP_CTRL_LZ_BLANK_EN.
module seg_disp_ctrl #(
  parameter int AN_COUNT   = 8,
  parameter int DIGIT_SIZE = 4,
  parameter int CE_DIV     = 100000,
  parameter int BLINK_DIV  = 512
) (
  input  logic                           clk,
  input  logic                           RESET,
  seg_disp_ctrl_if.slave                 bus,
  input  logic [AN_COUNT-1:0]            BLANK_IN,
  input  logic [AN_COUNT-1:0]            BLINK_EN,
  output logic                           CE_OUT,
  output logic [AN_COUNT*DIGIT_SIZE-1:0] NUMBER,
  output logic [AN_COUNT-1:0]            AN_MASK
);

  localparam int IDX_W = 3;
  localparam int PW    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [AN_COUNT*DIGIT_SIZE-1:0] number_q, number_d;
  logic [AN_COUNT-1:0]            an_mask_q, an_mask_d;
  logic [1:0]                     gnt_q, gnt_d;
  logic                           ptr_q, ptr_d;
  logic [PW-1:0]                  presc_q, presc_d;
  logic                           ce_q, ce_d;
  logic [BW-1:0]                  blink_cnt_q, blink_cnt_d;
  logic                           phase_q, phase_d;

  logic [1:0]            elig;
  logic                  win_valid;
  logic                  win;
  logic [IDX_W-1:0]      win_idx;
  logic [DIGIT_SIZE-1:0] win_data;
  logic [AN_COUNT-1:0]   lz_blank;

  // A requester whose GNT is high is ignored this cycle, so one held request
  // is never granted twice.
  always_comb begin
    elig      = bus.REQ & ~gnt_q;
    win_valid = |elig;
    win       = (elig == 2'b11) ? ~ptr_q : elig[1];
    win_idx   = win ? bus.WR_IDX1 : bus.WR_IDX0;
    win_data  = win ? bus.WR_DATA1 : bus.WR_DATA0;
    gnt_d     = 2'b00;
    ptr_d     = ptr_q;
    number_d  = number_q;
    if (win_valid) begin
      gnt_d[win] = 1'b1;
      ptr_d      = win;
      for (int i = 0; i < AN_COUNT; i++) begin
        if (win_idx == IDX_W'(i)) number_d[i*DIGIT_SIZE +: DIGIT_SIZE] = win_data;
      end
    end
  end

  always_comb begin
    presc_d     = presc_q;
    ce_d        = 1'b0;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (presc_q == PW'(CE_DIV - 1)) begin
      presc_d = '0;
      ce_d    = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (ce_q) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

`ifdef SEG_DISP_CTRL_LZ_BLANK_EN
  // Digit i is suppressed while it and every digit above it are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = AN_COUNT - 1; i >= 1; i--) begin
      zero_above  = zero_above & (number_q[i*DIGIT_SIZE +: DIGIT_SIZE] == '0);
      lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign an_mask_d = BLANK_IN | (BLINK_EN & {AN_COUNT{phase_q}}) | lz_blank;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      number_q    <= '0;
      an_mask_q   <= '1;
      gnt_q       <= 2'b00;
      ptr_q       <= 1'b1;
      presc_q     <= '0;
      ce_q        <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      number_q    <= number_d;
      an_mask_q   <= an_mask_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      presc_q     <= presc_d;
      ce_q        <= ce_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign bus.GNT = gnt_q;
  assign CE_OUT  = ce_q;
  assign NUMBER  = number_q;
  assign AN_MASK = an_mask_q;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl built with CE_DIV=4, BLINK_DIV=2.
module tb_seg_disp_ctrl;

  logic        clk;
  logic        RESET;
  logic [7:0]  BLANK_IN;
  logic [7:0]  BLINK_EN;
  logic        CE_OUT;
  logic [31:0] NUMBER;
  logic [7:0]  AN_MASK;

  int vectors;
  int miscompares;

  seg_disp_ctrl_if bus ();

  seg_disp_ctrl #(
    .AN_COUNT  (8),
    .DIGIT_SIZE(4),
    .CE_DIV    (4),
    .BLINK_DIV (2)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .bus     (bus.slave),
    .BLANK_IN(BLANK_IN),
    .BLINK_EN(BLINK_EN),
    .CE_OUT  (CE_OUT),
    .NUMBER  (NUMBER),
    .AN_MASK (AN_MASK)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] req, input logic [2:0] i0, input logic [3:0] d0,
                         input logic [2:0] i1, input logic [3:0] d1);
    bus.REQ      = req;
    bus.WR_IDX0  = i0;
    bus.WR_DATA0 = d0;
    bus.WR_IDX1  = i1;
    bus.WR_DATA1 = d1;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    check("rst_number", NUMBER, 32'h0);
    check("rst_an_mask", {24'h0, AN_MASK}, 32'hFF);
    check("rst_gnt", {30'h0, bus.GNT}, 32'h0);
    check("rst_ce", {31'h0, CE_OUT}, 32'h0);
    repeat (3) tick();
    RESET = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    BLANK_IN    = 8'h00;
    BLINK_EN    = 8'h00;
    RESET       = 1'b1;
    set_req(2'b00, 3'd0, 4'h0, 3'd0, 4'h0);
    #2;

    // reset and first cycle after release
    do_reset();
    tick();
    check("post_rst_an_mask", {24'h0, AN_MASK}, 32'h00);
    check("post_rst_number", NUMBER, 32'h0);
    check("post_rst_gnt", {30'h0, bus.GNT}, 32'h0);

    // single write, request dropped in the grant cycle
    set_req(2'b01, 3'd5, 4'hA, 3'd0, 4'h0);
    tick();
    check("single_gnt", {30'h0, bus.GNT}, 32'h1);
    check("single_number", NUMBER, 32'h00A00000);
    set_req(2'b00, 3'd5, 4'hA, 3'd0, 4'h0);
    tick();
    check("single_no_regnt", {30'h0, bus.GNT}, 32'h0);
    tick();
    check("single_idle_gnt", {30'h0, bus.GNT}, 32'h0);
    check("single_hold_number", NUMBER, 32'h00A00000);

    // reset while requester 1 is pending: dropped, then re-request granted
    set_req(2'b10, 3'd0, 4'h0, 3'd2, 4'h4);
    RESET = 1'b0;
    #1;
    check("midrst_number_async", NUMBER, 32'h0);
    tick();
    check("midrst_gnt", {30'h0, bus.GNT}, 32'h0);
    tick();
    check("midrst_number", NUMBER, 32'h0);
    set_req(2'b00, 3'd0, 4'h0, 3'd2, 4'h4);
    RESET = 1'b1;
    tick();
    check("midrst_release_gnt", {30'h0, bus.GNT}, 32'h0);
    set_req(2'b10, 3'd0, 4'h0, 3'd2, 4'h4);
    tick();
    check("rereq_gnt", {30'h0, bus.GNT}, 32'h2);
    check("rereq_number", NUMBER, 32'h00000400);
    set_req(2'b00, 3'd0, 4'h0, 3'd2, 4'h4);
    tick();

    // contention, REQ=11 held; data advances after each own grant
    set_req(2'b11, 3'd0, 4'h3, 3'd1, 4'h9);
    tick();
    check("cont1_gnt", {30'h0, bus.GNT}, 32'h1);
    check("cont1_number", NUMBER, 32'h00000403);
    bus.WR_DATA0 = 4'h7;
    tick();
    check("cont2_gnt", {30'h0, bus.GNT}, 32'h2);
    check("cont2_number", NUMBER, 32'h00000493);
    bus.WR_DATA1 = 4'hC;
    tick();
    check("cont3_gnt", {30'h0, bus.GNT}, 32'h1);
    check("cont3_number", NUMBER, 32'h00000497);
    tick();
    check("cont4_gnt", {30'h0, bus.GNT}, 32'h2);
    check("cont4_number", NUMBER, 32'h000004C7);
    set_req(2'b00, 3'd0, 4'h0, 3'd0, 4'h0);
    tick();
    check("cont_idle_gnt", {30'h0, bus.GNT}, 32'h0);

    // same-index collision on digit 3: the second grant's data remains
    set_req(2'b11, 3'd3, 4'h1, 3'd3, 4'h2);
    tick();
    check("same1_gnt", {30'h0, bus.GNT}, 32'h1);
    check("same1_number", NUMBER, 32'h000014C7);
    tick();
    check("same2_gnt", {30'h0, bus.GNT}, 32'h2);
    check("same2_number", NUMBER, 32'h000024C7);
    set_req(2'b00, 3'd0, 4'h0, 3'd0, 4'h0);
    tick();
    check("same_idle_gnt", {30'h0, bus.GNT}, 32'h0);
    check("same_final_number", NUMBER, 32'h000024C7);

    // refresh CE and blink schedule from a fresh reset
    BLANK_IN = 8'h02;
    BLINK_EN = 8'h81;
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      logic [7:0] exp_mask;
      tick();
      exp_mask = (k < 2) ? 8'h02 : ((((k - 2) / 8) % 2) == 1 ? 8'h83 : 8'h02);
      check($sformatf("ce_k%0d", k), {31'h0, CE_OUT}, {31'h0, (k % 4) == 0});
      check($sformatf("blink_k%0d", k), {24'h0, AN_MASK}, {24'h0, exp_mask});
    end

    // leading-zero case: NUMBER = 00000120, no static blanking or blink
    BLANK_IN = 8'h00;
    BLINK_EN = 8'h00;
    set_req(2'b11, 3'd1, 4'h2, 3'd2, 4'h1);
    tick();
    check("lz_w1_gnt", {30'h0, bus.GNT}, 32'h1);
    tick();
    check("lz_w2_gnt", {30'h0, bus.GNT}, 32'h2);
    set_req(2'b00, 3'd0, 4'h0, 3'd0, 4'h0);
    tick();
    tick();
    check("lz_number", NUMBER, 32'h00000120);
`ifdef SEG_DISP_CTRL_LZ_BLANK_EN
    check("lz_an_mask", {24'h0, AN_MASK}, 32'hF8);
`else
    check("lz_an_mask", {24'h0, AN_MASK}, 32'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
Name: seg_disp_ctrl

Overview:
- Front-end controller for the 8-digit seven_seg driver.
- Owns the driver's NUMBER digit register and AN_MASK blanking register.
- Arbitrates per-digit write requests from two requesters using round-robin.
- Generates the refresh clock-enable (CE_OUT) and applies a per-digit blink schedule on top of host blanking.

Parameters:
AN_COUNT, 8, number of digits/anodes (index width fixed at 3 bits for default)
DIGIT_SIZE, 4, bits per digit (hex nibble)
CE_DIV, 100000, clk cycles per CE_OUT pulse (>=2)
BLINK_DIV, 512, CE_OUT pulses per blink phase toggle (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
RESET  in  1  asynchronous, active-low reset
REQ  in  2  write request per requester; held until granted
WR_IDX0  in  3  digit index from requester 0
WR_DATA0  in  4  digit value from requester 0
WR_IDX1  in  3  digit index from requester 1
WR_DATA1  in  4  digit value from requester 1
GNT  out  2  one-hot, one-cycle pulse: write accepted at the preceding edge
BLANK_IN  in  8  static per-digit blank, 1 = off
BLINK_EN  in  8  per-digit blink enable
CE_OUT  out  1  one-cycle refresh enable, feeds seven_seg CE
NUMBER  out  32  digit i at bits [4i+3:4i], feeds seven_seg NUMBER
AN_MASK  out  8  1 = digit forced off, feeds seven_seg AN_MASK

Behaviour:
- Reset (RESET=0, async):
  - NUMBER=0, AN_MASK=8'hFF, GNT=0, CE_OUT=0.
  - Prescaler=0, blink counter=0, blink phase=0, round-robin pointer=1 (requester 0 wins first tie).
- Reset release: normal operation from the first clk edge with RESET=1.
- Reset mid-operation: a pending request is dropped without GNT. The requester must re-present after release.
- Eligibility:
  - Requester k is eligible when REQ[k]=1 and GNT[k]=0.
  - Because a requester sees GNT in the cycle after its write, it is never granted twice from one held request.
  - Maximum rate is one write per requester every 2 cycles.
- Arbitration at each edge:
  - Only one eligible requester: it wins.
  - Both eligible: winner is the one not equal to the pointer (last winner).
  - Pointer updates to the winner. No update if no grant.
- Write at the same edge: NUMBER[4*idx+3 -: 4] <= data of the winner, and GNT[winner] <= 1.
  - GNT is 0 for all other requesters and in all cycles with no grant.
  - Write-to-NUMBER latency = 1 edge. Other digits are unchanged.
- Same-index collision: the loser is not written that cycle. Its GNT comes on a later cycle, and its write then overwrites the digit (last-granted wins).
- Prescaler:
  - Counts 0..CE_DIV-1 and wraps.
  - CE_OUT=1 exactly in the cycle after the count reaches CE_DIV-1. Period is CE_DIV cycles.
- Blink:
  - Counter increments on each CE_OUT pulse.
  - At BLINK_DIV-1 with CE_OUT=1, the counter wraps to 0 and the phase toggles.
- AN_MASK is registered every cycle: AN_MASK <= BLANK_IN | (BLINK_EN & {8{phase}}).
  - Latency is 1 cycle from BLANK_IN/BLINK_EN/phase change.
- With BLINK_EN=0, the phase has no visible effect. The counters still run.

Optional Feature:
- Macro: SEG_DISP_CTRL_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit i (i>=1) is additionally blanked when digit i and every higher digit of NUMBER are 0.
  - Digit 0 is never suppressed.
  - The term is ORed into the AN_MASK expression and computed from the current NUMBER register, so it appears 1 cycle after the write edge.
- Undefined: no suppression; AN_MASK is exactly as above.

Test Plan:
- Reset: hold RESET=0 for 3 cycles, then release -> NUMBER=0, AN_MASK=8'hFF, GNT=0. First cycle after release with BLANK_IN=0, BLINK_EN=0 -> AN_MASK=8'h00.
- Single write: REQ=01, WR_IDX0=5, WR_DATA0=4'hA -> next cycle GNT=01 and NUMBER=32'h00A00000. Dropping REQ in that cycle yields no further GNT.
- Contention: REQ=11 held continuously, requester 0 writes idx 0 and requester 1 writes idx 1 -> GNT sequence 01,10,01,10. Same-index case (both idx 3, data 4'h1 vs 4'h2): final digit 3 equals the data of the second grant.
- Reset mid-request: assert RESET=0 while REQ=10 is pending -> no GNT, NUMBER=0. Re-requesting after release is granted.
- Timing, with CE_DIV=4 and BLINK_DIV=2: CE_OUT high 1 of every 4 cycles. With BLINK_EN=8'h81 and BLANK_IN=8'h02, AN_MASK alternates 8'h02/8'h83 every 8 cycles.
- With SEG_DISP_CTRL_LZ_BLANK_EN, NUMBER=32'h00000120, BLANK_IN=0 -> AN_MASK=8'hF8. Without the macro -> 8'h00.
